// File: rtl/pkt_browse_display.sv
// ==== pkt_browse_display: circular capture buffer, debounced browse buttons, 7-seg hex readout. Rev 1.0
// ==== Optional macro PKT_BROWSE_AUTO_REPEAT_EN enables hold-to-repeat on the browse buttons.
`default_nettype none

module pkt_browse_display #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic                clk,
  input  logic                BTNC,
  input  logic                BTNU,
  input  logic                BTND,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [ADDR_W:0]     count,
  output logic [ADDR_W-1:0]   sel_idx,
  output logic [N_DIGITS-1:0] an,
  output logic                ca,
  output logic                cb,
  output logic                cc,
  output logic                cd,
  output logic                ce,
  output logic                cf,
  output logic                cg,
  output logic                dp
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW4   = DATA_W / 4;
  localparam int AW4   = (ADDR_W + 3) / 4;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RF_W  = $clog2(REFRESH_DIV + 1);
  localparam int DG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [ADDR_W:0] C_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [6:0] C_DASH  = 7'b0111111;
  localparam logic [6:0] C_BLANK = 7'b1111111;

  // Segment word is {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [1:0] btn_raw;
  logic [1:0] btn_ev;
  assign btn_raw = {BTND, BTNU};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]      sync_q;
    logic            deb_q;
    logic            deb_prev_q;
    logic [DB_W-1:0] dcnt_q;
    logic            w_press;

    always_ff @(posedge clk) begin
      if (BTNC) begin
        sync_q     <= '0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        dcnt_q     <= '0;
      end else begin
        sync_q     <= {sync_q[0], btn_raw[b]};
        deb_prev_q <= deb_q;
        if (sync_q[1] != deb_q) begin
          if (dcnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            deb_q  <= sync_q[1];
            dcnt_q <= '0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end else begin
          dcnt_q <= '0;
        end
      end
    end

    assign w_press = deb_q & ~deb_prev_q;

`ifdef PKT_BROWSE_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYC + 1);
    logic [RP_W-1:0] rcnt_q;
    logic            rep_q;

    // rcnt_q is 0 on the press cycle, so rep_q fires exactly REPEAT_CYC cycles later.
    always_ff @(posedge clk) begin
      if (BTNC || !deb_q) begin
        rcnt_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        rep_q  <= (rcnt_q == RP_W'(REPEAT_CYC - 1));
        rcnt_q <= (rcnt_q == RP_W'(REPEAT_CYC - 1)) ? '0 : rcnt_q + 1'b1;
      end
    end

    assign btn_ev[b] = w_press | (rep_q & deb_q);
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_CYC > 0);
    assign btn_ev[b] = w_press;
`endif
  end

  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, sel_q, sel_d;
  logic [ADDR_W:0]   w_last;
  logic              w_at_last, w_up, w_dn;

  assign w_last    = count_q - 1'b1;
  assign w_at_last = ({1'b0, sel_q} == w_last);
  assign w_up      = btn_ev[0] & ~btn_ev[1];
  assign w_dn      = btn_ev[1] & ~btn_ev[0];

  always_comb begin
    count_d = count_q;
    sel_d   = sel_q;
    if (wr_en && count_q != C_FULL) count_d = count_q + 1'b1;
    if (count_q != '0) begin
      if (w_up)
        sel_d = w_at_last ? '0 : sel_q + 1'b1;
      else if (w_dn)
        sel_d = (sel_q == '0) ? w_last[ADDR_W-1:0] : sel_q - 1'b1;
      else if (wr_en && count_q != C_FULL && w_at_last)
        sel_d = sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (BTNC) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      count_q  <= count_d;
      sel_q    <= sel_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] w_raddr;

  // When full, count_q's low bits are zero and the oldest entry sits at wr_ptr_q.
  assign w_raddr = wr_ptr_q - count_q[ADDR_W-1:0] + sel_q;

  always_ff @(posedge clk) begin
    if (wr_en && !BTNC) mem_q[wr_ptr_q] <= wr_data;
    rd_q <= mem_q[w_raddr];
  end

  logic [RF_W-1:0]     div_q;
  logic [DG_W-1:0]     dig_q;
  logic [N_DIGITS-1:0] an_q;
  logic [6:0]          seg_q, w_seg;
  logic                dp_q, w_dp;
  logic [AW4*4-1:0]    w_sel_pad;
  int                  w_di;

  assign w_sel_pad = (AW4*4)'(sel_q);

  always_comb begin
    w_di  = int'(dig_q);
    w_seg = C_BLANK;
    w_dp  = (w_di == DW4) ? 1'b0 : 1'b1;
    if (w_di < DW4)
      w_seg = (count_q == '0) ? C_DASH : hex7(4'(rd_q >> (4 * w_di)));
    else if (w_di < DW4 + AW4)
      w_seg = (count_q == '0) ? C_DASH : hex7(4'(w_sel_pad >> (4 * (w_di - DW4))));
  end

  always_ff @(posedge clk) begin
    if (BTNC) begin
      div_q <= '0;
      dig_q <= '0;
      an_q  <= '1;
      seg_q <= C_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(N_DIGITS'(1) << dig_q);
      seg_q <= w_seg;
      dp_q  <= w_dp;
      if (div_q == RF_W'(REFRESH_DIV - 1)) begin
        div_q <= '0;
        dig_q <= (dig_q == DG_W'(N_DIGITS - 1)) ? '0 : dig_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign sel_idx = sel_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign {cg, cf, ce, cd, cc, cb, ca} = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_browse_display.sv
// Scoreboard bench for pkt_browse_display: stimulus queues expectations, a monitor compares them.
`default_nettype none

module tb_pkt_browse_display;

  logic       clk = 1'b0;
  logic       BTNC, BTNU, BTND, wr_en;
  logic [15:0] wr_data;
  logic [3:0] count;
  logic [2:0] sel_idx;
  logic [7:0] an;
  logic       ca, cb, cc, cd, ce, cf, cg, dp;

  pkt_browse_display #(
    .DATA_W(16), .ADDR_W(3), .N_DIGITS(8),
    .REFRESH_DIV(2), .DEBOUNCE_CYC(4), .REPEAT_CYC(8)
  ) dut (
    .clk(clk), .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND),
    .wr_en(wr_en), .wr_data(wr_data), .count(count), .sel_idx(sel_idx),
    .an(an), .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg), .dp(dp)
  );

  always #5 clk = ~clk;

  localparam int K_COUNT = 0, K_SEL = 1, K_DIG = 2, K_AN = 3, K_SEG = 4;

  typedef struct {
    string name;
    int    kind;
    int    digit;
    int    val;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_busy = 1'b0;

  task automatic check(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
  endtask

  task automatic expect_v(input string nm, input int kind, input int digit, input int val);
    exp_t e;
    e.name = nm; e.kind = kind; e.digit = digit; e.val = val;
    q.push_back(e);
  endtask

  // Digit value is {dp, g, f, e, d, c, b, a}, all active-low.
  initial begin
    exp_t     e;
    int       act;
    bit       found;
    logic [7:0] tgt;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_busy = 1'b1;
        e = q.pop_front();
        act = -1;
        case (e.kind)
          K_COUNT: act = int'(count);
          K_SEL:   act = int'(sel_idx);
          K_AN:    act = int'(an);
          K_SEG:   act = int'({dp, cg, cf, ce, cd, cc, cb, ca});
          default: begin
            tgt = ~(8'd1 << e.digit);
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
              if (an == tgt) found = 1'b1;
              else @(negedge clk);
            end
            if (found) act = int'({dp, cg, cf, ce, cd, cc, cb, ca});
          end
        endcase
        check(e.name, act, e.val);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (q.size() > 0 || mon_busy); i++) @(negedge clk);
    if (q.size() > 0 || mon_busy) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic write(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // which: 1 = up, 2 = down, 3 = both
  task automatic press(input int which, input int n);
    BTNU = which[0]; BTND = which[1];
    tick(n);
    BTNU = 1'b0; BTND = 1'b0;
    tick(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    BTNC = 1'b1; BTNU = 1'b0; BTND = 1'b0; wr_en = 1'b0; wr_data = '0;

    // Reset: everything dark while BTNC is held
    tick(3);
    expect_v("rst_an", K_AN, 0, 8'hFF);
    expect_v("rst_seg", K_SEG, 0, 8'hFF);
    drain();
    BTNC = 1'b0;
    tick(4);
    expect_v("rst_count", K_COUNT, 0, 0);
    expect_v("rst_sel", K_SEL, 0, 0);
    expect_v("empty_d0", K_DIG, 0, 8'hBF);
    expect_v("empty_d3", K_DIG, 3, 8'hBF);
    expect_v("empty_d4", K_DIG, 4, 8'h3F);
    expect_v("empty_d7", K_DIG, 7, 8'hFF);
    drain();

    // Two writes; newest tracked, then BTNU wraps 1 -> 0
    write(16'h1234);
    write(16'hABCD);
    tick(3);
    expect_v("track_sel1", K_SEL, 0, 1);
    drain();
    press(1, 10);
    expect_v("t2_count", K_COUNT, 0, 2);
    expect_v("t2_sel", K_SEL, 0, 0);
    expect_v("t2_d0", K_DIG, 0, 8'h99);
    expect_v("t2_d1", K_DIG, 1, 8'hB0);
    expect_v("t2_d2", K_DIG, 2, 8'hA4);
    expect_v("t2_d3", K_DIG, 3, 8'hF9);
    expect_v("t2_d4", K_DIG, 4, 8'h40);
    expect_v("t2_d5", K_DIG, 5, 8'hFF);
    drain();

    // Glitch rejected, then three real BTND presses
    press(2, 3);
    expect_v("glitch_sel", K_SEL, 0, 0);
    drain();
    press(2, 10);
    expect_v("dn1_sel", K_SEL, 0, 1);
    drain();
    press(2, 10);
    expect_v("dn2_sel", K_SEL, 0, 0);
    drain();
    press(2, 10);
    expect_v("dn3_sel", K_SEL, 0, 1);
    drain();

    // Overwrite: ten words 0..9 leave 2..9 in the buffer
    for (int i = 0; i < 10; i++) write(16'(i));
    tick(4);
    expect_v("wrap_count", K_COUNT, 0, 8);
    expect_v("wrap_sel7", K_SEL, 0, 7);
    expect_v("wrap_d0", K_DIG, 0, 8'h90);
    expect_v("wrap_d1", K_DIG, 1, 8'hC0);
    expect_v("wrap_d3", K_DIG, 3, 8'hC0);
    expect_v("wrap_d4", K_DIG, 4, 8'h78);
    drain();
    press(1, 10);
    expect_v("wrap_up_sel", K_SEL, 0, 0);
    expect_v("oldest_d0", K_DIG, 0, 8'hA4);
    expect_v("oldest_d4", K_DIG, 4, 8'h40);
    drain();

    // Simultaneous up/down cancels
    press(3, 10);
    expect_v("both_sel", K_SEL, 0, 0);
    drain();

    // Tracking after fresh reset
    BTNC = 1'b1;
    tick(2);
    BTNC = 1'b0;
    write(16'h00A1);
    write(16'h00B2);
    write(16'h00C3);
    tick(2);
    expect_v("trk_count3", K_COUNT, 0, 3);
    expect_v("trk_sel2", K_SEL, 0, 2);
    drain();
    write(16'h00D4);
    tick(4);
    expect_v("trk_sel3", K_SEL, 0, 3);
    expect_v("trk_d0", K_DIG, 0, 8'h99);
    expect_v("trk_d1", K_DIG, 1, 8'hA1);
    expect_v("trk_d4", K_DIG, 4, 8'h30);
    drain();

    // Long hold on BTNU with a full buffer
    write(16'h00E5);
    write(16'h00F6);
    write(16'h0017);
    write(16'h0028);
    tick(2);
    expect_v("hold_count", K_COUNT, 0, 8);
    expect_v("hold_sel_pre", K_SEL, 0, 7);
    drain();
    press(1, 38);
`ifdef PKT_BROWSE_AUTO_REPEAT_EN
    expect_v("hold_sel", K_SEL, 0, 4);
`else
    expect_v("hold_sel", K_SEL, 0, 0);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
